ibex_xif_offload_ctrl: RTL and testbench

Core-side initiator for the coprocessor eXtension interface (issue / commit / result channels). It takes one offload candidate from the ID stage and issues it to the coprocessor. It then sends a commit or kill for that instruction, collects the result, and drives a single-cycle register-file write. One instruction is outstanding at a time. Instances sit between ibex_id_stage and an external accelerator.

---
 rtl/ibex_pkg.sv | 58 +++++
 rtl/ibex_xif_offload_ctrl.sv | 111 +++++++++++
 tb/tb_ibex_xif_offload_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_pkg.sv
// ibex_pkg: shared coprocessor-interface types and the offload controller state encoding
package ibex_pkg;

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_H = 2'b10,
    PRIV_LVL_M = 2'b11
  } priv_lvl_e;

  localparam int unsigned X_ID_WIDTH = 4;
  localparam int unsigned X_NUM_RS   = 3;

  typedef struct packed {
    logic [31:0]                 instr;
    priv_lvl_e                   mode;
    logic [X_ID_WIDTH-1:0]       id;
    logic [X_NUM_RS-1:0][31:0]   rs;
    logic [X_NUM_RS-1:0]         rs_valid;
    logic [5:0]                  ecs;
    logic                        ecs_valid;
  } x_issue_req_t;

  typedef struct packed {
    logic accept;
    logic writeback;
    logic dualwrite;
    logic dualread;
    logic loadstore;
    logic ecswrite;
    logic exc;
  } x_issue_resp_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic                  commit_kill;
  } x_commit_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [31:0]           data;
    logic [4:0]            rd;
    logic                  we;
    logic [2:0]            ecswe;
    logic [5:0]            ecsdata;
    logic                  exc;
    logic [5:0]            exccode;
    logic                  err;
    logic                  dbg;
  } x_result_t;

  typedef enum logic [1:0] {
    XIF_IDLE   = 2'd0,
    XIF_COMMIT = 2'd1,
    XIF_RESULT = 2'd2
  } xif_off_state_e;

endpackage

// File: rtl/ibex_xif_offload_ctrl.sv
// ibex_xif_offload_ctrl: issues one offload at a time over the coprocessor interface, commits/kills it, writes back the result.
// Optional result watchdog enabled by defining IBEX_XIF_RESULT_TIMEOUT_EN.
module ibex_xif_offload_ctrl import ibex_pkg::*; #(
  parameter int unsigned X_ID_WIDTH    = ibex_pkg::X_ID_WIDTH,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          off_req_valid_i,
  input  logic [31:0]   off_instr_i,
  input  logic [31:0]   off_rs1_i,
  input  logic [31:0]   off_rs2_i,
  input  logic [1:0]    off_rs_valid_i,
  input  priv_lvl_e     off_mode_i,
  input  logic          off_flush_i,
  output logic          off_done_o,
  output logic          off_illegal_o,
  output logic          err_o,
  output logic          rf_we_o,
  output logic [4:0]    rf_waddr_o,
  output logic [31:0]   rf_wdata_o,
  output logic          x_issue_valid_o,
  input  logic          x_issue_ready_i,
  output x_issue_req_t  x_issue_req_o,
  input  x_issue_resp_t x_issue_resp_i,
  output logic          x_commit_valid_o,
  output x_commit_t     x_commit_o,
  input  logic          x_result_valid_i,
  output logic          x_result_ready_o,
  input  x_result_t     x_result_i
);
  xif_off_state_e state_q, state_d;
  logic [X_ID_WIDTH-1:0] id_q;
  logic writeback_q;
  logic issue_hs, result_hit, timeout;
  logic unused_fields;
  assign unused_fields = ^{x_issue_resp_i.dualwrite, x_issue_resp_i.dualread, x_issue_resp_i.loadstore,
                           x_issue_resp_i.ecswrite, x_issue_resp_i.exc, x_result_i.ecswe,
                           x_result_i.ecsdata, x_result_i.exccode, x_result_i.dbg};
  assign issue_hs   = x_issue_valid_o & x_issue_ready_i;
  // id_q already advanced past the committed instruction when RESULT is entered
  assign result_hit = state_q == XIF_RESULT && x_result_valid_i && x_result_i.id == id_q - 1'b1;
  assign rf_we_o    = result_hit & x_result_i.we & |x_result_i.rd;
  assign rf_waddr_o = result_hit ? x_result_i.rd : '0;
  assign rf_wdata_o = result_hit ? x_result_i.data : '0;
`ifdef IBEX_XIF_RESULT_TIMEOUT_EN
  localparam int unsigned CntW = TimeoutCycles > 1 ? $clog2(TimeoutCycles) : 1;
  logic [CntW-1:0] cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= state_q == XIF_RESULT ? cnt_q + 1'b1 : '0;
  end
  assign timeout          = state_q == XIF_RESULT && cnt_q == CntW'(TimeoutCycles - 1);
  // stale results from a timed-out instruction are drained everywhere
  assign x_result_ready_o = 1'b1;
`else
  logic unused_timeout;
  assign unused_timeout   = ^TimeoutCycles;
  assign timeout          = 1'b0;
  assign x_result_ready_o = state_q == XIF_RESULT;
`endif
  always_comb begin
    x_issue_req_o          = '0;
    x_issue_req_o.instr    = off_instr_i;
    x_issue_req_o.mode     = off_mode_i;
    x_issue_req_o.id       = id_q;
    x_issue_req_o.rs[0]    = off_rs1_i;
    x_issue_req_o.rs[1]    = off_rs2_i;
    x_issue_req_o.rs_valid = X_NUM_RS'(off_rs_valid_i);
  end
  assign x_commit_o.id          = id_q;
  assign x_commit_o.commit_kill = off_flush_i;
  always_comb begin
    state_d          = state_q;
    x_issue_valid_o  = 1'b0;
    x_commit_valid_o = 1'b0;
    off_done_o       = 1'b0;
    off_illegal_o    = 1'b0;
    err_o            = 1'b0;
    case (state_q)
      XIF_IDLE: begin
        x_issue_valid_o = off_req_valid_i & ~off_flush_i;
        state_d         = issue_hs && x_issue_resp_i.accept ? XIF_COMMIT : XIF_IDLE;
        off_done_o      = issue_hs & ~x_issue_resp_i.accept;
        off_illegal_o   = issue_hs & ~x_issue_resp_i.accept;
      end
      XIF_COMMIT: begin
        x_commit_valid_o = 1'b1;
        state_d          = !off_flush_i && writeback_q ? XIF_RESULT : XIF_IDLE;
        off_done_o       = off_flush_i | ~writeback_q;
      end
      XIF_RESULT: begin
        state_d    = result_hit || timeout ? XIF_IDLE : XIF_RESULT;
        off_done_o = result_hit | timeout;
        err_o      = result_hit ? x_result_i.err | x_result_i.exc : timeout;
      end
      default: state_d = XIF_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= XIF_IDLE;
      id_q        <= '0;
      writeback_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= state_q == XIF_COMMIT ? id_q + 1'b1 : id_q;
      writeback_q <= issue_hs ? x_issue_resp_i.writeback : writeback_q;
    end
  end
endmodule

// File: tb/tb_ibex_xif_offload_ctrl.sv
// tb_ibex_xif_offload_ctrl: randomized offload traffic, expectations queued by a reference model and checked by a monitor.
module tb_ibex_xif_offload_ctrl;
  import ibex_pkg::*;
  localparam int TMO = 8;
`ifdef IBEX_XIF_RESULT_TIMEOUT_EN
  localparam bit READY_IDLE = 1'b1;
`else
  localparam bit READY_IDLE = 1'b0;
`endif
  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic off_req_valid_i = 1'b0, off_flush_i = 1'b0;
  logic [31:0] off_instr_i = '0, off_rs1_i = '0, off_rs2_i = '0;
  logic [1:0] off_rs_valid_i = '0;
  priv_lvl_e off_mode_i = PRIV_LVL_M;
  logic off_done_o, off_illegal_o, err_o, rf_we_o;
  logic [4:0] rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic x_issue_valid_o, x_commit_valid_o, x_result_ready_o;
  logic x_issue_ready_i = 1'b0, x_result_valid_i = 1'b0;
  x_issue_req_t x_issue_req_o;
  x_issue_resp_t x_issue_resp_i = '0;
  x_commit_t x_commit_o;
  x_result_t x_result_i = '0;

  ibex_xif_offload_ctrl #(.X_ID_WIDTH(4), .TimeoutCycles(TMO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .off_req_valid_i(off_req_valid_i), .off_instr_i(off_instr_i),
    .off_rs1_i(off_rs1_i), .off_rs2_i(off_rs2_i), .off_rs_valid_i(off_rs_valid_i), .off_mode_i(off_mode_i),
    .off_flush_i(off_flush_i), .off_done_o(off_done_o), .off_illegal_o(off_illegal_o), .err_o(err_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .x_issue_valid_o(x_issue_valid_o),
    .x_issue_ready_i(x_issue_ready_i), .x_issue_req_o(x_issue_req_o), .x_issue_resp_i(x_issue_resp_i),
    .x_commit_valid_o(x_commit_valid_o), .x_commit_o(x_commit_o), .x_result_valid_i(x_result_valid_i),
    .x_result_ready_o(x_result_ready_o), .x_result_i(x_result_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] instr, rs1, rs2, data;
    logic [1:0]  rsv;
    priv_lvl_e   mode;
    bit          accept, wb, kill, probe, abort, tmo, we, err, exc;
    int          rdy_dly, n_idle, n_bad;
    logic [3:0]  bad_off;
    logic [4:0]  rd;
  } txn_t;
  typedef struct { logic [3:0] id; logic kill; } commit_t;
  typedef struct { logic illegal, err, we; logic [4:0] waddr; logic [31:0] wdata; } done_t;

  x_issue_req_t q_iss[$];
  commit_t q_com[$];
  done_t q_done[$];
  int n_checks = 0, n_fail = 0;
  logic [3:0] model_id = '0;

  function automatic void check(string name, logic [191:0] act, logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void unexpected(string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got output with no expectation queued", name);
  endfunction

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (x_issue_valid_o && x_issue_ready_i) begin
        if (q_iss.size() == 0) unexpected("issue");
        else check("issue_req", 192'(x_issue_req_o), 192'(q_iss.pop_front()));
      end
      if (x_commit_valid_o) begin
        if (q_com.size() == 0) unexpected("commit");
        else begin
          commit_t c;
          c = q_com.pop_front();
          check("commit", 192'({x_commit_o.id, x_commit_o.commit_kill}), 192'({c.id, c.kill}));
        end
      end
      if (off_done_o) begin
        if (q_done.size() == 0) unexpected("done");
        else begin
          done_t d;
          d = q_done.pop_front();
          check("done_fields", 192'({off_illegal_o, err_o, rf_we_o, rf_waddr_o, rf_wdata_o}),
                192'({d.illegal, d.err, d.we, d.waddr, d.wdata}));
        end
      end else check("pulse_without_done", 192'({off_illegal_o, err_o, rf_we_o}), 192'(0));
    end
  end

  task automatic do_txn(input txn_t t);
    logic [3:0] iid;
    x_issue_req_t e;
    if (t.probe) begin
      off_req_valid_i = 1'b1; off_flush_i = 1'b1; x_issue_ready_i = 1'b1;
      @(negedge clk_i);
      check("flush_suppress", 192'(x_issue_valid_o), 192'(0));
      tick;
    end
    off_req_valid_i = 1'b1; off_flush_i = 1'b0; x_issue_ready_i = 1'b0;
    off_instr_i = t.instr; off_rs1_i = t.rs1; off_rs2_i = t.rs2; off_rs_valid_i = t.rsv; off_mode_i = t.mode;
    x_issue_resp_i = '0; x_issue_resp_i.accept = t.accept; x_issue_resp_i.writeback = t.wb;
    for (int i = 0; i < t.rdy_dly; i++) begin
      @(negedge clk_i);
      check("ready_idle", 192'(x_result_ready_o), 192'(READY_IDLE));
      tick;
    end
    iid = model_id;
    e = '0; e.instr = t.instr; e.mode = t.mode; e.id = iid; e.rs[0] = t.rs1; e.rs[1] = t.rs2; e.rs_valid = {1'b0, t.rsv};
    q_iss.push_back(e);
    if (!t.accept) q_done.push_back('{1'b1, 1'b0, 1'b0, 5'd0, 32'd0});
    x_issue_ready_i = 1'b1;
    tick;
    off_req_valid_i = 1'b0; x_issue_ready_i = 1'b0; x_issue_resp_i = '0;
    if (!t.accept) return;
    off_flush_i = t.kill;
    q_com.push_back('{iid, t.kill});
    if (t.kill || !t.wb) q_done.push_back('{1'b0, 1'b0, 1'b0, 5'd0, 32'd0});
    @(negedge clk_i);
    check("ready_commit", 192'(x_result_ready_o), 192'(READY_IDLE));
    tick;
    off_flush_i = 1'b0;
    model_id++;
    if (t.kill || !t.wb) return;
    if (t.abort) begin
      repeat (2) tick;
      #2 rst_ni = 1'b0;
      #1 check("abort_outputs", 192'({x_commit_valid_o, off_done_o, rf_we_o, x_issue_valid_o}), 192'(0));
      @(posedge clk_i);
      #1 rst_ni = 1'b1;
      model_id = '0;
      return;
    end
    if (t.tmo) begin
      for (int i = 1; i <= TMO; i++) begin
        if (i == TMO) q_done.push_back('{1'b0, 1'b1, 1'b0, 5'd0, 32'd0});
        @(negedge clk_i);
        check("timeout_pulse", 192'(off_done_o), 192'(i == TMO));
        tick;
      end
      x_result_valid_i = 1'b1; x_result_i = '0; x_result_i.id = iid; x_result_i.we = 1'b1;
      x_result_i.rd = 5'd7; x_result_i.data = $urandom;
      @(negedge clk_i);
      check("late_result_ready", 192'(x_result_ready_o), 192'(1));
      tick;
      x_result_valid_i = 1'b0; x_result_i = '0;
      return;
    end
    for (int i = 0; i < t.n_idle; i++) begin
      off_flush_i = 1'($urandom);
      @(negedge clk_i);
      check("ready_result", 192'(x_result_ready_o), 192'(1));
      tick;
    end
    off_flush_i = 1'b0;
    for (int i = 0; i < t.n_bad; i++) begin
      x_result_valid_i = 1'b1; x_result_i = '0; x_result_i.id = iid + t.bad_off;
      x_result_i.we = 1'b1; x_result_i.rd = 5'($urandom_range(1, 31)); x_result_i.data = $urandom;
      @(negedge clk_i);
      check("ready_bad_result", 192'(x_result_ready_o), 192'(1));
      tick;
    end
    x_result_valid_i = 1'b1; x_result_i = '0; x_result_i.id = iid; x_result_i.we = t.we;
    x_result_i.rd = t.rd; x_result_i.data = t.data; x_result_i.err = t.err; x_result_i.exc = t.exc;
    q_done.push_back('{1'b0, t.err | t.exc, t.we && t.rd != 0, t.rd, t.data});
    tick;
    x_result_valid_i = 1'b0; x_result_i = '0;
  endtask

  function automatic txn_t rnd_txn();
    txn_t t;
    t.instr = $urandom; t.rs1 = $urandom; t.rs2 = $urandom; t.data = $urandom;
    t.rsv = 2'($urandom); t.mode = priv_lvl_e'($urandom_range(0, 3));
    t.accept = $urandom_range(0, 9) < 8; t.wb = $urandom_range(0, 9) < 7; t.kill = $urandom_range(0, 3) == 0;
    t.probe = $urandom_range(0, 4) == 0; t.abort = 1'b0; t.tmo = 1'b0;
    t.we = 1'($urandom); t.err = $urandom_range(0, 6) == 0; t.exc = $urandom_range(0, 9) == 0;
    t.rdy_dly = $urandom_range(0, 2); t.n_idle = $urandom_range(0, 3);
    t.n_bad = $urandom_range(0, 2) == 0 ? $urandom_range(1, 2) : 0;
    t.bad_off = 4'($urandom_range(1, 15));
    t.rd = $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom_range(1, 31));
    return t;
  endfunction

  function automatic txn_t plain_txn();
    txn_t t;
    t = rnd_txn();
    t.accept = 1'b1; t.wb = 1'b1; t.kill = 1'b0; t.probe = 1'b0; t.err = 1'b0; t.exc = 1'b0;
    t.n_bad = 0; t.we = 1'b1; t.rd = 5'd9;
    return t;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    @(negedge clk_i);
    check("reset_outputs", 192'({x_issue_valid_o, x_commit_valid_o, off_done_o, off_illegal_o, err_o,
                                rf_we_o, rf_waddr_o, rf_wdata_o}), 192'(0));
    check("reset_ready", 192'(x_result_ready_o), 192'(READY_IDLE));
    tick;
    rst_ni = 1'b1;
    t = plain_txn(); t.instr = 32'h00708293; t.rs1 = 32'd10; t.rs2 = '0; t.rsv = 2'b01; t.mode = PRIV_LVL_M;
    t.n_bad = 1; t.bad_off = 4'd3; t.rd = 5'd5; t.data = 32'd17;
    do_txn(t);
    t = plain_txn(); t.accept = 1'b0; do_txn(t);
    t = plain_txn(); t.kill = 1'b1; do_txn(t);
    t = plain_txn(); t.rd = 5'd0; do_txn(t);
    t = plain_txn(); t.err = 1'b1; do_txn(t);
    t = plain_txn(); t.probe = 1'b1; t.wb = 1'b0; do_txn(t);
    t = plain_txn(); t.abort = 1'b1; do_txn(t);
`ifdef IBEX_XIF_RESULT_TIMEOUT_EN
    t = plain_txn(); t.tmo = 1'b1; do_txn(t);
`endif
    for (int i = 0; i < 17; i++) begin
      t = plain_txn(); t.wb = 1'b0; do_txn(t);
    end
    for (int i = 0; i < 40; i++) do_txn(rnd_txn());
    repeat (3) tick;
    check("queues_drained", 192'(q_iss.size() + q_com.size() + q_done.size()), 192'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
